// File: rtl/qrb_pkg.sv
// rtl/qrb_pkg.sv - shared default widths and packed-word type for the query row buffer
package qrb_pkg;

    localparam int DEF_DATA_WIDTH  = 11;
    localparam int DEF_FETCH_WIDTH = 2;
    localparam int DEF_ADDR_WIDTH  = 7;
    localparam int DEF_DEPTH       = 128;

    typedef logic [DEF_FETCH_WIDTH*DEF_DATA_WIDTH-1:0] packed_word_t;

endpackage

// File: rtl/query_row_packer.sv
// rtl/query_row_packer.sv - dequeues upstream words and packs FETCH_WIDTH lanes into one wide word
module query_row_packer
    import qrb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fsm_enable,
    input  logic [DATA_WIDTH-1:0]             sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic                              word_valid,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] word_data
);

    localparam int CNT_WIDTH = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int LANE_REGS = (FETCH_WIDTH > 1) ? FETCH_WIDTH - 1 : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(FETCH_WIDTH - 1);

    logic [CNT_WIDTH-1:0]  cnt;
    // The last lane is never stored: it is taken straight from the FIFO head on the write edge.
    logic [DATA_WIDTH-1:0] lanes [LANE_REGS];

    // rst_n is active-high despite its name
    assign sender_deq = fsm_enable & sender_empty_n & ~rst_n;
    assign word_valid = sender_deq & (cnt == LAST_LANE);

    // Assemble the packed word from stored lanes plus the live head word in the top lane
    always_comb begin
        word_data = '0;
        for (int i = 0; i < FETCH_WIDTH - 1; i++) begin
            word_data[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
        end
        word_data[(FETCH_WIDTH-1)*DATA_WIDTH +: DATA_WIDTH] = sender_data;
    end

    // Lane counter and lane capture; a stall simply holds both
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt <= '0;
            for (int i = 0; i < LANE_REGS; i++) begin
                lanes[i] <= '0;
            end
        end else if (sender_deq) begin
            for (int i = 0; i < FETCH_WIDTH - 1; i++) begin
                if (cnt == CNT_WIDTH'(i)) begin
                    lanes[i] <= sender_data;
                end
            end
            if (cnt == LAST_LANE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/query_row_buffer_unit.sv
// rtl/query_row_buffer_unit.sv - ping-pong row buffer; QUERY_ROW_STATUS_EN adds wr_count and a read-before-fill assertion
module query_row_buffer_unit
    import qrb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fsm_enable,
    input  logic [DATA_WIDTH-1:0]             sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    input  logic                              ren,
    input  logic [ADDR_WIDTH-1:0]             radr,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
    output logic                              wr_bank,
`ifdef QUERY_ROW_STATUS_EN
    output logic [ADDR_WIDTH:0]               wr_count,
`endif
    output logic                              row_done
);

    localparam int PW = FETCH_WIDTH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

    logic                  word_valid;
    logic [PW-1:0]         word_data;
    logic [ADDR_WIDTH-1:0] wadr;
    // Both banks share one array; the bank select is the top address bit.
    logic [PW-1:0]         mem [2*DEPTH];

    query_row_packer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_packer (
        .clk            (clk),
        .rst_n          (rst_n),
        .fsm_enable     (fsm_enable),
        .sender_data    (sender_data),
        .sender_empty_n (sender_empty_n),
        .sender_deq     (sender_deq),
        .word_valid     (word_valid),
        .word_data      (word_data)
    );

    // RAM write port: contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (word_valid) begin
            mem[{wr_bank, wadr}] <= word_data;
        end
    end

    // RAM read port on the opposite bank; wr_bank here is the pre-swap value
    always_ff @(posedge clk) begin
        if (rst_n) begin
            receiver_data <= '0;
        end else if (ren) begin
            receiver_data <= mem[{~wr_bank, radr}];
        end
    end

    // Write address, unconditional bank swap on the last address, and the row_done pulse
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wadr     <= '0;
            wr_bank  <= 1'b0;
            row_done <= 1'b0;
        end else begin
            row_done <= word_valid && (wadr == LAST_ADR);
            if (word_valid) begin
                wadr <= wadr + 1'b1;
                if (wadr == LAST_ADR) begin
                    wr_bank <= ~wr_bank;
                end
            end
        end
    end

`ifdef QUERY_ROW_STATUS_EN
    logic row_done_seen;

    assign wr_count = {1'b0, wadr};

    // Remember whether any bank has ever been completed since reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_done_seen <= 1'b0;
        end else if (row_done) begin
            row_done_seen <= 1'b1;
        end
    end

    // A read before the first swap targets a bank that was never filled
    assert property (@(posedge clk) disable iff (rst_n) !(ren && !row_done_seen && !row_done));
`endif

endmodule

// File: tb/tb_query_row_buffer_unit.sv
// tb/tb_query_row_buffer_unit.sv - self-checking bench for query_row_buffer_unit
module tb_query_row_buffer_unit;
    import qrb_pkg::*;

    localparam int DW = 11;
    localparam int FW = 2;
    localparam int AW = 2;
    localparam int DP = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               fsm_enable;
    logic [DW-1:0]      sender_data;
    logic               sender_empty_n;
    logic               sender_deq;
    logic               ren;
    logic [AW-1:0]      radr;
    logic [FW*DW-1:0]   receiver_data;
    logic               wr_bank;
    logic               row_done;

    always #5 clk = ~clk;

    query_row_buffer_unit #(
        .DATA_WIDTH  (DW),
        .FETCH_WIDTH (FW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fsm_enable     (fsm_enable),
        .sender_data    (sender_data),
        .sender_empty_n (sender_empty_n),
        .sender_deq     (sender_deq),
        .ren            (ren),
        .radr           (radr),
        .receiver_data  (receiver_data),
        .wr_bank        (wr_bank),
        .row_done       (row_done)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    packed_word_t  exp_mem [2][DP];
    logic          m_bank;
    int            m_wadr;
    int            m_cnt;
    logic [DW-1:0] m_lane;
    logic          m_done;
    packed_word_t  m_rd;
    packed_word_t  sb [$];

    typedef struct {
        logic          ren;
        logic [AW-1:0] radr;
        packed_word_t  exp;
    } rd_vec_t;

    rd_vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the currently driven inputs; model advances alongside the DUT
    task automatic step();
        logic deq_e;
        logic rd_e;
        #1;
        deq_e = fsm_enable & sender_empty_n & ~rst_n;
        check("sender_deq", {63'd0, sender_deq}, {63'd0, deq_e});
        rd_e = ren & ~rst_n;
        if (rst_n) begin
            m_cnt  = 0;
            m_wadr = 0;
            m_bank = 1'b0;
            m_done = 1'b0;
            m_lane = '0;
            m_rd   = '0;
        end else begin
            m_done = 1'b0;
            if (rd_e) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: read issued with no expected value at %0t", $time);
                end else begin
                    m_rd = sb.pop_front();
                end
            end
            if (deq_e) begin
                if (m_cnt == FW - 1) begin
                    exp_mem[m_bank][m_wadr] = {sender_data, m_lane};
                    m_cnt = 0;
                    if (m_wadr == DP - 1) begin
                        m_bank = ~m_bank;
                        m_done = 1'b1;
                    end
                    m_wadr = (m_wadr + 1) % DP;
                end else begin
                    m_lane = sender_data;
                    m_cnt  = m_cnt + 1;
                end
            end
        end
        @(posedge clk);
        #2;
        check("wr_bank", {63'd0, wr_bank}, {63'd0, m_bank});
        check("row_done", {63'd0, row_done}, {63'd0, m_done});
        check("receiver_data", {42'd0, receiver_data}, {42'd0, m_rd});
    endtask

    // Push n consecutive values, optionally with random empty cycles (bounded per word)
    task automatic feed(input int first, input int n, input bit stall);
        int tries;
        for (int k = 0; k < n; k++) begin
            sender_data = DW'(first + k);
            fsm_enable  = 1'b1;
            tries = 0;
            do begin
                sender_empty_n = stall ? (($urandom_range(0, 2) != 0) || (tries >= 6)) : 1'b1;
                step();
                tries++;
            end while (!sender_empty_n);
        end
        sender_empty_n = 1'b0;
    endtask

    task automatic rd_const(input int adr, input packed_word_t exp);
        ren  = 1'b1;
        radr = AW'(adr);
        sb.push_back(exp);
        step();
        ren  = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b1;
        fsm_enable     = 1'b1;
        sender_empty_n = 1'b1;
        sender_data    = '0;
        ren            = 1'b1;
        radr           = '0;
        m_bank = 1'b0; m_wadr = 0; m_cnt = 0; m_lane = '0; m_done = 1'b0; m_rd = '0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DP; a++)
                exp_mem[b][a] = '0;

        tbl[0] = '{1'b1, 2'd0, {11'd2, 11'd1}};
        tbl[1] = '{1'b1, 2'd1, {11'd4, 11'd3}};
        tbl[2] = '{1'b1, 2'd2, {11'd6, 11'd5}};
        tbl[3] = '{1'b1, 2'd3, {11'd8, 11'd7}};
        tbl[4] = '{1'b0, 2'd1, {11'd8, 11'd7}};
        tbl[5] = '{1'b1, 2'd1, {11'd4, 11'd3}};

        // reset: no dequeue even with enable and data present
        step();
        step();

        // continuous fill of bank 0, swap after the 8th dequeue
        rst_n = 1'b0;
        ren   = 1'b0;
        feed(1, 8, 1'b0);

        // table-driven readback of bank 0, including a hold cycle
        for (int i = 0; i < 6; i++) begin
            ren  = tbl[i].ren;
            radr = tbl[i].radr;
            if (tbl[i].ren) sb.push_back(tbl[i].exp);
            step();
            if (!tbl[i].ren) check("read_hold", {42'd0, receiver_data}, {42'd0, tbl[i].exp});
        end
        ren = 1'b0;

        // same data with random stalls into bank 1, swap back to bank 0
        feed(1, 8, 1'b1);
        check("bank_after_second_row", {63'd0, wr_bank}, 64'd0);
        for (int a = 0; a < DP; a++)
            rd_const(a, {DW'(2*a + 2), DW'(2*a + 1)});

        // fsm_enable stall between lanes
        sender_empty_n = 1'b1;
        sender_data    = 11'd2;
        fsm_enable     = 1'b1;
        step();
        fsm_enable  = 1'b0;
        sender_data = 11'd99;
        repeat (3) step();
        fsm_enable  = 1'b1;
        sender_data = 11'd3;
        step();
        feed(4, 6, 1'b0);
        rd_const(0, {11'd3, 11'd2});
        rd_const(1, {11'd5, 11'd4});

        // reset mid-word discards the partial lane and clears read data
        sender_empty_n = 1'b1;
        sender_data    = 11'd50;
        step();
        rst_n = 1'b1;
        step();
        rst_n          = 1'b0;
        sender_empty_n = 1'b0;
        repeat (2) step();
        feed(60, 8, 1'b0);
        rd_const(0, {11'd61, 11'd60});
        rd_const(3, {11'd67, 11'd66});

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/query_row_buffer_unit.md
# query_row_buffer_unit

Ingest stage for query rows: pulls DATA_WIDTH words from an upstream first-word-fall-through FIFO and packs FETCH_WIDTH of them into one wide word. Each packed word is written sequentially into a ping-pong RAM of two banks, each DEPTH words deep. While one bank fills, the downstream search engine reads the other bank by address. The unit sits between the input clock-domain-crossing FIFO and the patch-matching datapath, in the core clock domain.

## Interface
- DATA_WIDTH, 11: width of one upstream word.
- FETCH_WIDTH, 2: upstream words packed per RAM word.
- ADDR_WIDTH, 7: RAM address width.
- DEPTH, 128: words per bank; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous and active-high; the name is kept for codebase consistency.
- fsm_enable  in  1  high while the top FSM is in the load phase; gates dequeuing.
- sender_data  in  DATA_WIDTH  upstream FIFO head word, valid when sender_empty_n=1.
- sender_empty_n  in  1  upstream FIFO non-empty.
- sender_deq  out  1  pops the upstream FIFO; combinational.
- ren  in  1  read enable for the read bank.
- radr  in  ADDR_WIDTH  read address.
- receiver_data  out  FETCH_WIDTH*DATA_WIDTH  registered read data.
- wr_bank  out  1  bank currently being written; the read bank is !wr_bank.
- row_done  out  1  one-cycle pulse after a bank fills and swaps.

## Operation
- sender_deq = fsm_enable & sender_empty_n & !rst_n.
- On every cycle with sender_deq=1, sender_data is captured into lane `cnt`, then `cnt` increments. Lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]; the first word goes in lane 0 (LSB).
- On the dequeue that fills the last lane (cnt=FETCH_WIDTH-1):
  - The packed word is written at that edge to bank wr_bank at address wadr, using earlier lanes plus the current sender_data.
  - cnt returns to 0 and wadr increments.
- When the write at wadr=DEPTH-1 completes:
  - wadr wraps to 0.
  - wr_bank toggles.
  - row_done=1 for the following cycle.
- The swap is unconditional; the reader must consume the read bank before the next swap.
- Read: when ren=1, receiver_data ← bank[!wr_bank][radr] at the edge. When ren=0, receiver_data holds its value.
- Deasserting fsm_enable in the middle of a word stalls packing. Partial lanes and cnt are retained.
- Reset sets cnt=0, wadr=0, wr_bank=0, row_done=0, receiver_data=0 and lane registers to 0. RAM contents are not cleared. Reset applied mid-operation discards any partial word.

## Timing
- Packing: a word dequeued at edge t becomes part of the RAM word written at the edge of its lane-(FETCH_WIDTH-1) dequeue. With no stall and FETCH_WIDTH=2, one RAM write occurs every 2 cycles.
- Write-to-read: a word written at edge t is readable by ren at edge t+1 only once its bank has become the read bank.
- Read latency: 1 cycle. ren/radr sampled at edge t give receiver_data valid after edge t.
- A read on the same edge as a swap uses the pre-swap read bank.
- row_done is asserted in the cycle after the swap edge. wr_bank changes at that same edge.
- sender_deq has zero latency from sender_empty_n and fsm_enable.

## Configuration
- QUERY_ROW_STATUS_EN defined:
  - Adds output wr_count [ADDR_WIDTH:0] = number of packed words written to the current write bank (0..DEPTH-1). Its reset value is 0.
  - Adds a simulation assertion that flags ren with radr while row_done was never seen since reset.
- Undefined: neither port nor assertion exists; all other behaviour is identical.

## Structure
- A shared package (qrb_pkg) holds:
  - the default widths DATA_WIDTH=11, FETCH_WIDTH=2, ADDR_WIDTH=7, DEPTH=128;
  - the typedef of the packed word (logic [FETCH_WIDTH*DATA_WIDTH-1:0]).
- One sub-module, `query_row_packer`, contains the lane counter, lane registers and sender_deq. It emits a pulse together with the packed word.
- The top level holds both RAM banks (inferred 1R1W), the wadr counter, the bank select and row_done.

## Test plan
- Use DEPTH=4, ADDR_WIDTH=2.
- Reset, then hold sender_empty_n=1 and fsm_enable=1 while feeding 1,2,3,… → writes {2,1},{4,3},{6,5},{8,7} to bank 0. row_done pulses once, after the 8th dequeue. wr_bank becomes 1.
- After the swap, ren=1 with radr=0..3 → receiver_data equals {2,1},{4,3},{6,5},{8,7}, each one cycle after its request.
- Random sender_empty_n stalls, same data → identical packed contents. sender_deq is never high while sender_empty_n=0.
- fsm_enable=0 after one lane is captured → sender_deq=0 and nothing is written. Re-enabling completes that word with the next input (e.g. {3,2} after 2 then 3).
- Assert rst_n mid-word → the partial word is discarded, the next word lands at address 0 of bank 0, and receiver_data reads 0 until a read is issued.
- Fill 8 words → wr_bank returns to 0 and bank 1 holds the second row while bank 0 is overwritten.
